fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, in-order response
// buffering, and a valid/ready handoff to decode with redirect flush and stale-response drop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  localparam int unsigned   AW     = $clog2(DEPTH);
  localparam int unsigned   CW     = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [31:0]   Nop    = 32'h0000_0013;

  logic          started_q;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   ipc_q   [DEPTH];
  logic [31:0]   tag_q   [DEPTH];

  logic credit_ok, req_fire, resp_drop, fifo_push, fifo_pop;

  always_comb begin
    // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
    credit_ok      = ({1'b0, inflight_q} + {1'b0, count_q}) < {1'b0, DepthC};
    imem_req_valid = started_q && !redirect_valid && credit_ok;
    imem_req_addr  = pc_q & ~32'h3;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_drop      = imem_resp_valid && (drop_q != '0);
    fifo_push      = imem_resp_valid && !resp_drop && !redirect_valid;
    dec_valid      = (count_q != '0);
    fifo_pop       = dec_valid && dec_ready && !redirect_valid;
    dec_instr      = dec_valid ? instr_q[rd_ptr_q] : Nop;
    dec_pc         = dec_valid ? ipc_q[rd_ptr_q] : '0;
  end

  always_comb begin
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
    pc_d       = req_fire ? (pc_q + 32'd4) : pc_q;
    drop_d     = resp_drop ? (drop_q - CW'(1)) : drop_q;
    count_d    = count_q + CW'(fifo_push) - CW'(fifo_pop);
    rd_ptr_d   = rd_ptr_q + AW'(fifo_pop);
    wr_ptr_d   = wr_ptr_q + AW'(fifo_push);
    tag_wr_d   = tag_wr_q + AW'(req_fire);
    tag_rd_d   = tag_rd_q + AW'(imem_resp_valid);
    if (redirect_valid) begin
      pc_d     = redirect_pc & ~32'h3;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d   = inflight_d;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q  <= 1'b0;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      instr_q    <= '{default: Nop};
      ipc_q      <= '{default: '0};
      tag_q      <= '{default: '0};
    end else begin
      started_q  <= 1'b1;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      if (req_fire) tag_q[tag_wr_q] <= imem_req_addr;
      if (fifo_push) begin
        instr_q[wr_ptr_q] <= imem_resp_data;
        ipc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> (count_q != DepthC));
  a_resp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable in-order memory, a program-order scoreboard for
// decode delivery and fetch addresses, directed scenarios and randomized redirect traffic.
module tb_fetch_stage;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] instr;
  } dl_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  int          nvec = 0;
  int          nmis = 0;
  int          cyc  = 0;
  int          lat  = 1;
  bit          rdy_rand = 0;
  req_t        pend[$];
  dl_t         deliv[$];
  logic [31:0] acc_q[$];
  int          acc_n = 0;
  int          del_n = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  bit          redir_prev = 0;
  bit          hold_q = 0;
  logic [31:0] hold_addr = '0;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h00B0_0113;
      32'h0000_0008: return 32'h0020_81B3;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_deliv(input int n, input string tag);
    for (int i = 0; i < 200 && deliv.size() < n; i++) @(posedge clk);
    #1;
    chk(tag, 32'(deliv.size() >= n), 1);
  endtask

  task automatic wait_acc(input int n, input string tag);
    for (int i = 0; i < 200 && acc_q.size() < n; i++) @(posedge clk);
    #1;
    chk(tag, 32'(acc_q.size() >= n), 1);
  endtask

  // Memory: fixed latency from acceptance, in order, responses never stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= '0;
      imem_req_ready  <= 1'b0;
    end else begin
      imem_req_ready <= rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= memfn(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_resp_valid <= 1'b0;
        imem_resp_data  <= $urandom;
      end
    end
  end

  // Scoreboard: decode must see program order from the last redirect target, each word matching
  // memory; fetch addresses must step by 4 from the same target.
  always begin
    req_t r;
    dl_t  d;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      exp_pc     = RESET_PC;
      exp_fetch  = RESET_PC;
      redir_prev = 0;
      hold_q     = 0;
      acc_n      = 0;
      del_n      = 0;
      deliv.delete();
      acc_q.delete();
    end else begin
      if (redir_prev) chk("flush_dec_valid", 32'(dec_valid), 0);
      if (hold_q && !redirect_valid) begin
        chk("req_hold_valid", 32'(imem_req_valid), 1);
        chk("req_hold_addr", imem_req_addr, hold_addr);
      end
      chk("credit", 32'((pend.size() + int'(imem_resp_valid)) <= DEPTH), 1);
      if (redirect_valid) begin
        chk("redir_no_req", 32'(imem_req_valid), 0);
        exp_pc     = redirect_pc & ~32'h3;
        exp_fetch  = exp_pc;
        redir_prev = 1;
        hold_q     = 0;
      end else begin
        redir_prev = 0;
        if (dec_valid && dec_ready) begin
          chk("dec_pc", dec_pc, exp_pc);
          chk("dec_instr", dec_instr, memfn(exp_pc));
          d.cyc = cyc; d.pc = dec_pc; d.instr = dec_instr;
          deliv.push_back(d);
          exp_pc += 32'd4;
          del_n++;
        end
        if (imem_req_valid && imem_req_ready) begin
          chk("fetch_addr", imem_req_addr, exp_fetch);
          r.addr = imem_req_addr;
          r.due  = cyc + 1 + lat;
          pend.push_back(r);
          acc_q.push_back(imem_req_addr);
          exp_fetch += 32'd4;
          acc_n++;
        end
        hold_q    = imem_req_valid && !imem_req_ready;
        hold_addr = imem_req_addr;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit found;
    logic [31:0] last;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_dec_instr", dec_instr, 32'h0000_0013);
    chk("rst_dec_pc", dec_pc, 0);

    // Streaming, latency 1.
    dec_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_acc(1, "first_req_seen");
    if (acc_q.size() >= 1) chk("first_req_addr", acc_q[0], RESET_PC);
    wait_deliv(3, "stream_count");
    if (deliv.size() >= 3) begin
      chk("stream_pc0", deliv[0].pc, 32'h0);
      chk("stream_in0", deliv[0].instr, 32'h00A0_0093);
      chk("stream_pc1", deliv[1].pc, 32'h4);
      chk("stream_in1", deliv[1].instr, 32'h00B0_0113);
      chk("stream_pc2", deliv[2].pc, 32'h8);
      chk("stream_in2", deliv[2].instr, 32'h0020_81B3);
      chk("stream_rate", 32'((deliv[2].cyc - deliv[0].cyc) <= 3), 1);
    end

    // Decode backpressure fills exactly DEPTH credits, then requests stop.
    dec_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_req_idle", 32'(imem_req_valid), 0);
    chk("bp_outstanding", 32'(acc_n - del_n), DEPTH);
    chk("bp_dec_valid", 32'(dec_valid), 1);
    nb = deliv.size();
    last = deliv[nb-1].pc;
    dec_ready = 1'b1;
    wait_deliv(nb + 4, "bp_resume_count");
    if (deliv.size() >= nb + 4) begin
      chk("bp_resume_pc0", deliv[nb].pc, last + 32'd4);
      chk("bp_resume_pc3", deliv[nb+3].pc, last + 32'd16);
    end

    // Reset while the FIFO is full.
    dec_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0; lat = 3;
    @(negedge clk);
    chk("midrst_dec_valid", 32'(dec_valid), 0);
    chk("midrst_req_valid", 32'(imem_req_valid), 0);
    chk("midrst_dec_instr", dec_instr, 32'h0000_0013);

    // Redirect with two requests in flight at latency 3.
    dec_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (acc_n >= 2) break;
    end
    #1;
    chk("inflight_setup", 32'(acc_n), 2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_deliv(1, "redir_count");
    if (deliv.size() >= 1) begin
      chk("redir_pc", deliv[0].pc, 32'h0000_0100);
      chk("redir_instr", deliv[0].instr, memfn(32'h0000_0100));
    end

    // Unaligned redirect near the top of the address space wraps to zero.
    @(posedge clk); #1;
    acc_q.delete();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_acc(2, "wrap_count");
    if (acc_q.size() >= 2) begin
      chk("wrap_addr0", acc_q[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", acc_q[1], 32'h0000_0000);
    end

    // Redirect coinciding with a response and a decode pop, then a second redirect.
    @(posedge clk); #1 rst_n = 1'b0; lat = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (imem_resp_valid && dec_valid && dec_ready) begin
        found = 1;
        break;
      end
    end
    chk("sim_found", 32'(found), 1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    @(posedge clk); #1 redirect_pc = 32'h0000_0200;
    @(negedge clk);
    chk("sim_flush", 32'(dec_valid), 0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    deliv.delete();
    wait_deliv(1, "sim_count");
    if (deliv.size() >= 1) chk("sim_pc", deliv[0].pc, 32'h0000_0200);

    // Random traffic: random latency, memory stalls, decode stalls and redirects.
    rdy_rand = 1;
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1 rst_n = 1'b0; redirect_valid = 1'b0; lat = $urandom_range(1, 4);
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 400; c++) begin
        @(posedge clk); #1;
        dec_ready      = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 15) == 0);
        redirect_pc    = ($urandom_range(0, 3) == 0) ?
                         (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      end
      redirect_valid = 1'b0;
      dec_ready      = 1'b1;
      repeat (20) @(posedge clk);
      chk("rand_progress", 32'(del_n > 0), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
